// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Holds the FSM state encoding, the digit width and a constant log2 helper.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_W = 4;

  // Ceiling log2, usable in constant expressions for counter sizing.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decade.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [BCD_W-1:0] i_dig,
  output logic [BCD_W-1:0] o_dig
);

  assign o_dig = (i_dig >= BCD_W'(5)) ? (i_dig + BCD_W'(3)) : i_dig;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with optional
// two's-complement input, start/ready/valid handshake and overflow reporting.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [WIDTH-1:0]          bin,
  input  logic                      is_signed,
  output logic                      ready,
  output logic                      valid,
  output logic [BCD_W*DIGITS-1:0]   bcd,
  output logic                      neg,
  output logic                      overflow
);

  localparam int CNT_W   = clog2(WIDTH + 1);
  localparam int BCD_TOT = BCD_W * DIGITS;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_mag;
  logic [BCD_TOT-1:0]   r_dig;
  logic                 r_ovf;
  logic                 r_neg;
  logic                 r_ready;
  logic                 r_valid;
  logic [BCD_TOT-1:0]   r_bcd;
  logic                 r_neg_out;
  logic                 r_ovf_out;

  logic                 w_load_neg;
  logic [WIDTH-1:0]     w_mag_load;
  logic                 w_last;
  logic [BCD_TOT-1:0]   w_adj;
  logic [BCD_TOT-1:0]   w_dig_shift;
  logic [WIDTH-1:0]     w_mag_shift;
  logic                 w_carry;

  // The most negative value negates onto itself, which read unsigned is the
  // correct magnitude.
  assign w_load_neg = is_signed & bin[WIDTH-1];
  assign w_mag_load = w_load_neg ? (~bin + WIDTH'(1)) : bin;
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_dig (r_dig[g*BCD_W +: BCD_W]),
      .o_dig (w_adj[g*BCD_W +: BCD_W])
    );
  end

  // Bit falling off the top digit means the magnitude exceeds the digit range.
  assign {w_carry, w_dig_shift, w_mag_shift} = {w_adj, r_mag, 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_mag     <= '0;
      r_dig     <= '0;
      r_ovf     <= 1'b0;
      r_neg     <= 1'b0;
      r_ready   <= 1'b1;
      r_valid   <= 1'b0;
      r_bcd     <= '0;
      r_neg_out <= 1'b0;
      r_ovf_out <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state <= SHIFT;
            r_ready <= 1'b0;
            r_cnt   <= '0;
            r_mag   <= w_mag_load;
            r_dig   <= '0;
            r_ovf   <= 1'b0;
            r_neg   <= w_load_neg;
          end else begin
            r_state <= IDLE;
            r_ready <= 1'b1;
          end
        end
        SHIFT: begin
          r_dig <= w_dig_shift;
          r_mag <= w_mag_shift;
          r_ovf <= r_ovf | w_carry;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_state   <= DONE;
            r_ready   <= 1'b1;
            r_valid   <= 1'b1;
            r_bcd     <= w_dig_shift;
            r_neg_out <= r_neg;
            r_ovf_out <= r_ovf | w_carry;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ready    = r_ready;
  assign valid    = r_valid;
  assign bcd      = r_bcd;
  assign neg      = r_neg_out;
  assign overflow = r_ovf_out;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: three configurations (8/3, 8/2, 16/5) checked
// cycle by cycle against an arithmetic reference plus literal expectations.
module tb_bin2bcd_seq;

  typedef struct {
    int          due;
    logic [19:0] bcd;
    logic        neg;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [2:0]  st;
  logic [15:0] bn [3];
  logic [2:0]  sg;
  logic [2:0]  rdy, vld, ng, ov;
  logic [11:0] bcd0;
  logic [7:0]  bcd1;
  logic [19:0] bcd2;

  int   cyc;
  int   checks;
  int   errors;
  exp_t q [3][$];
  exp_t last [3];

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) u0 (
    .clk(clk), .rst(rst), .start(st[0]), .bin(bn[0][7:0]), .is_signed(sg[0]),
    .ready(rdy[0]), .valid(vld[0]), .bcd(bcd0), .neg(ng[0]), .overflow(ov[0]));

  bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) u1 (
    .clk(clk), .rst(rst), .start(st[1]), .bin(bn[1][7:0]), .is_signed(sg[1]),
    .ready(rdy[1]), .valid(vld[1]), .bcd(bcd1), .neg(ng[1]), .overflow(ov[1]));

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) u2 (
    .clk(clk), .rst(rst), .start(st[2]), .bin(bn[2]), .is_signed(sg[2]),
    .ready(rdy[2]), .valid(vld[2]), .bcd(bcd2), .neg(ng[2]), .overflow(ov[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int w_of(input int k);
    return (k == 2) ? 16 : 8;
  endfunction

  function automatic int d_of(input int k);
    return (k == 0) ? 3 : ((k == 1) ? 2 : 5);
  endfunction

  function automatic logic [19:0] bcd_of(input int k);
    if (k == 0) return {8'h0, bcd0};
    if (k == 1) return {12'h0, bcd1};
    return bcd2;
  endfunction

  // Reference: decimal digits of the magnitude by division, range by compare.
  function automatic exp_t model(input int k, input logic [15:0] v, input bit s, input int due);
    exp_t    e;
    longint  mag, p, m;
    int      w, d;
    w = w_of(k);
    d = d_of(k);
    e.due = due;
    e.neg = s && v[w-1];
    mag = longint'(v);
    if (e.neg) mag = (longint'(1) << w) - mag;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    e.ovf = (mag >= p);
    m = mag % p;
    e.bcd = '0;
    for (int i = 0; i < d; i++) begin
      e.bcd[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, want);
    end
  endtask

  task automatic cmp(input int k);
    exp_t e;
    bit   due;
    logic r_exp;
    due   = (q[k].size() > 0) && (q[k][0].due == cyc);
    r_exp = !((q[k].size() > 0) && !due);
    if (due) begin
      e = q[k].pop_front();
      last[k] = e;
    end else begin
      e = last[k];
    end
    checks++;
    if (vld[k] !== due || rdy[k] !== r_exp || bcd_of(k) !== e.bcd ||
        ng[k] !== e.neg || ov[k] !== e.ovf) begin
      errors++;
      $display("FAIL scoreboard dut%0d cyc %0d got v=%b r=%b bcd=%h n=%b o=%b want v=%b r=%b bcd=%h n=%b o=%b",
               k, cyc, vld[k], rdy[k], bcd_of(k), ng[k], ov[k], due, r_exp, e.bcd, e.neg, e.ovf);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) cmp(k);
    end
  end

  task automatic clear_model();
    for (int k = 0; k < 3; k++) begin
      q[k].delete();
      last[k] = '{due: 0, bcd: 20'h0, neg: 1'b0, ovf: 1'b0};
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic launch(input int k, input logic [15:0] v, input bit s, output int due);
    st[k] = 1'b1;
    bn[k] = v;
    sg[k] = s;
    @(posedge clk);
    #1;
    due = cyc + w_of(k);
    q[k].push_back(model(k, v, s, due));
    st[k] = 1'b0;
  endtask

  task automatic settle(input int due);
    int lim;
    lim = 200;
    while (cyc != due && lim > 0) begin
      @(posedge clk);
      #1;
      lim--;
    end
    if (cyc != due) chk("settle_timeout", 32'(cyc), 32'(due));
  endtask

  task automatic conv(input int k, input logic [15:0] v, input bit s);
    int due;
    launch(k, v, s, due);
    settle(due);
  endtask

  int due1, due2;
  logic [15:0] tail [6];

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    st = '0;
    sg = '0;
    for (int k = 0; k < 3; k++) bn[k] = '0;
    clear_model();
    rst = 1'b1;
    idle(3);
    chk("reset_state0", {rdy[0], vld[0], ng[0], ov[0], bcd_of(0)}, {1'b1, 1'b0, 1'b0, 1'b0, 20'h0});
    chk("reset_state2", {rdy[2], vld[2], ng[2], ov[2], bcd_of(2)}, {1'b1, 1'b0, 1'b0, 1'b0, 20'h0});
    rst = 1'b0;
    idle(2);

    // Unsigned full-scale, then hold of the result after the valid pulse.
    conv(0, 16'd255, 1'b0);
    chk("u255", {vld[0], ng[0], ov[0], bcd_of(0)}, {1'b1, 1'b0, 1'b0, 20'h255});
    idle(1);
    chk("u255_hold", {vld[0], bcd_of(0)}, {1'b0, 20'h255});

    conv(0, 16'h80, 1'b1);
    chk("s80", {vld[0], ng[0], bcd_of(0)}, {1'b1, 1'b1, 20'h128});
    conv(0, 16'h9C, 1'b1);
    chk("s9C", {vld[0], ng[0], bcd_of(0)}, {1'b1, 1'b1, 20'h100});
    conv(0, 16'h7F, 1'b1);
    chk("s7F", {vld[0], ng[0], bcd_of(0)}, {1'b1, 1'b0, 20'h127});
    conv(0, 16'h00, 1'b1);
    chk("s00", {vld[0], ng[0], ov[0], bcd_of(0)}, {1'b1, 1'b0, 1'b0, 20'h0});
    idle(2);

    conv(1, 16'd100, 1'b0);
    chk("ovf100", {vld[1], ov[1], bcd_of(1)}, {1'b1, 1'b1, 20'h00});
    conv(1, 16'd99, 1'b0);
    chk("ovf99", {vld[1], ov[1], bcd_of(1)}, {1'b1, 1'b0, 20'h99});
    idle(2);

    // Start held high: second operand is taken in the DONE cycle.
    st[0] = 1'b1;
    bn[0] = 16'd42;
    sg[0] = 1'b0;
    @(posedge clk);
    #1;
    due1 = cyc + 8;
    q[0].push_back(model(0, 16'd42, 1'b0, due1));
    bn[0] = 16'd7;
    settle(due1);
    chk("held42", {vld[0], bcd_of(0)}, {1'b1, 20'h042});
    @(posedge clk);
    #1;
    due2 = cyc + 8;
    q[0].push_back(model(0, 16'd7, 1'b0, due2));
    st[0] = 1'b0;
    settle(due2);
    chk("held7", {vld[0], bcd_of(0)}, {1'b1, 20'h007});
    idle(2);

    // Starts during SHIFT are dropped and operand changes are not sampled.
    launch(0, 16'd123, 1'b0, due1);
    idle(1);
    st[0] = 1'b1;
    bn[0] = 16'd9;
    idle(1);
    st[0] = 1'b0;
    idle(1);
    bn[0] = 16'd250;
    sg[0] = 1'b1;
    settle(due1);
    chk("ignore_mid", {vld[0], ng[0], bcd_of(0)}, {1'b1, 1'b0, 20'h123});
    idle(12);

    // Asynchronous reset between edges aborts the conversion immediately.
    launch(0, 16'd200, 1'b0, due1);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    clear_model();
    #1;
    chk("rst_async", {rdy[0], vld[0], ng[0], ov[0], bcd_of(0)}, {1'b1, 1'b0, 1'b0, 1'b0, 20'h0});
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(12);
    conv(0, 16'd58, 1'b0);
    chk("after_rst58", {vld[0], bcd_of(0)}, {1'b1, 20'h058});
    idle(2);

    // 16-bit configuration: spread of values back to back, then edges.
    for (int i = 0; i < 1500; i++) begin
      conv(2, (i < 200) ? 16'(i) : 16'(i * 43 + 7), 1'b0);
    end
    tail[0] = 16'd9999;
    tail[1] = 16'd10000;
    tail[2] = 16'd59999;
    tail[3] = 16'd60000;
    tail[4] = 16'd65534;
    tail[5] = 16'd65535;
    for (int i = 0; i < 6; i++) conv(2, tail[i], 1'b0);
    chk("w16max", {vld[2], ng[2], ov[2], bcd_of(2)}, {1'b1, 1'b0, 1'b0, 20'h65535});
    conv(2, 16'h8000, 1'b1);
    chk("w16min", {vld[2], ng[2], ov[2], bcd_of(2)}, {1'b1, 1'b1, 1'b0, 20'h32768});
    conv(2, 16'hFFFF, 1'b1);
    chk("w16m1", {vld[2], ng[2], bcd_of(2)}, {1'b1, 1'b1, 20'h00001});
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got cyc %0d want finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
